// File: rtl/free_list_pkg.sv
// free_list_pkg: shared sizing constants and tag types for the physical-register free list.
//   N_WAY      dispatch/retire width
//   N_PHYS_REG number of physical tags (0..N_PHYS_REG-1)
//   CDB_BITS   tag width
//   FL_DEPTH   circular buffer entries
package free_list_pkg;
   localparam int N_WAY = 2;
   localparam int N_PHYS_REG = 64;
   localparam int CDB_BITS = 6;
   localparam int FL_DEPTH = 64;
   localparam int PTR_BITS = $clog2(FL_DEPTH);
   localparam int CNT_BITS = $clog2(N_WAY + 1);
   localparam int COUNT_BITS = 7;
   // arch regs 0..31 map to tags 1..32 at reset, so tags 33..63 start free
   localparam int RESET_BASE = 33;
   localparam int RESET_FREE = 31;
   typedef logic [CDB_BITS-1:0] FREE_TAG;
   typedef logic [PTR_BITS-1:0] ptr_t;
   typedef logic [CNT_BITS-1:0] way_cnt_t;
   typedef logic [COUNT_BITS-1:0] count_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire/rollback bundle between the rename stage and the free list.
//   dis_req     per-way dispatch request          (master -> slave)
//   ret_valid   per-way retire valid              (master -> slave)
//   ret_told    per-way freed old tag             (master -> slave)
//   rollback    full squash                       (master -> slave)
//   pr_freelist per-way offered tag               (slave -> master)
//   free_count  free tags held                    (slave -> master)
//   dis_stall   fewer than N_WAY tags free        (slave -> master)
interface free_list_if
   import free_list_pkg::*;
();
   logic [N_WAY-1:0] dis_req;
   logic [N_WAY-1:0] ret_valid;
   FREE_TAG [N_WAY-1:0] ret_told;
   logic rollback;
   FREE_TAG [N_WAY-1:0] pr_freelist;
   count_t free_count;
   logic dis_stall;
   modport master (
      output dis_req, ret_valid, ret_told, rollback,
      input pr_freelist, free_count, dis_stall
   );
   modport slave (
      input dis_req, ret_valid, ret_told, rollback,
      output pr_freelist, free_count, dis_stall
   );
endinterface

// File: rtl/free_list_prefix_count.sv
// fl_prefix_count: per-way exclusive prefix popcount and total popcount of an N_WAY-bit vector.
//   vec    in  request/valid vector
//   prefix out number of bits set below each way
//   total  out number of bits set overall
module fl_prefix_count
   import free_list_pkg::*;
(
   input logic [N_WAY-1:0] vec,
   output way_cnt_t [N_WAY-1:0] prefix,
   output way_cnt_t total
);
   always_comb begin
      for (int i = 0; i < N_WAY; i++) begin
         prefix[i] = '0;
         for (int j = 0; j < i; j++) prefix[i] = prefix[i] + way_cnt_t'(vec[j]);
      end
      total = prefix[N_WAY-1] + way_cnt_t'(vec[N_WAY-1]);
   end
endmodule

// File: rtl/free_list.sv
// free_list: circular-buffer physical tag free list with speculative and architectural heads.
//   clock  in  rising-edge clock
//   reset  in  synchronous active-high reset
//   fl     slave side of free_list_if (dispatch, retire, rollback, offered tags, count, stall)
module free_list
   import free_list_pkg::*;
(
   input logic clock,
   input logic reset,
   free_list_if.slave fl
);
   FREE_TAG fl_buf [FL_DEPTH];
   ptr_t head, tail, arch_head;
   count_t count;
   way_cnt_t [N_WAY-1:0] dis_pre, ret_pre;
   way_cnt_t dis_tot, ret_tot;
   logic grant;
   ptr_t tail_nxt, arch_nxt, roll_cnt;
   count_t alloc;
   fl_prefix_count u_dis (.vec(fl.dis_req), .prefix(dis_pre), .total(dis_tot));
   fl_prefix_count u_ret (.vec(fl.ret_valid), .prefix(ret_pre), .total(ret_tot));
   // grant uses only the registered count: same-cycle frees are not yet allocatable
   assign grant = !fl.rollback && (count_t'(dis_tot) <= count);
   assign alloc = grant ? count_t'(dis_tot) : '0;
   assign tail_nxt = tail + ptr_t'(ret_tot);
   assign arch_nxt = arch_head + ptr_t'(ret_tot);
   assign roll_cnt = tail_nxt - arch_nxt;
   assign fl.free_count = count;
   assign fl.dis_stall = count < count_t'(N_WAY);
   always_comb begin
      for (int k = 0; k < N_WAY; k++) fl.pr_freelist[k] = fl_buf[head + ptr_t'(dis_pre[k])];
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL_DEPTH; i++)
            fl_buf[i] <= (i < RESET_FREE) ? FREE_TAG'(RESET_BASE + i) : '0;
         head <= '0;
         arch_head <= '0;
         tail <= ptr_t'(RESET_FREE);
         count <= count_t'(RESET_FREE);
      end else begin
         for (int k = 0; k < N_WAY; k++)
            if (fl.ret_valid[k]) fl_buf[tail + ptr_t'(ret_pre[k])] <= fl.ret_told[k];
         tail <= tail_nxt;
         arch_head <= arch_nxt;
         // rollback restores the retired view; a full buffer cannot occur since tag 0 is never held
         head <= fl.rollback ? arch_nxt : head + ptr_t'(alloc);
         count <= fl.rollback ? {1'b0, roll_cnt} : count - alloc + count_t'(ret_tot);
      end
   end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed scoreboard bench for free_list.
module tb_free_list;
   import free_list_pkg::*;
   typedef enum {S_PR0, S_PR1, S_CNT, S_STALL} sig_e;
   typedef struct {
      string tag;
      sig_e sig;
      logic [31:0] val;
   } exp_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   exp_t sb [$];
   int compared = 0;
   int mismatched = 0;
   free_list_if fl ();
   free_list dut (.clock(clock), .reset(reset), .fl(fl));
   always #5 clock = ~clock;
   always @(posedge clock) begin
      if (!reset && fl.ret_valid != '0) begin
         logic bad;
         bad = (fl.free_count == 7'd63);
         for (int k = 0; k < N_WAY; k++) if (fl.ret_valid[k] && fl.ret_told[k] == '0) bad = 1'b1;
         compared++;
         assert (!bad) else begin
            mismatched++;
            $error("FAIL illegal_retire: observed count=%0d valid=%b told0=%0d told1=%0d required count<63 and told!=0",
                   fl.free_count, fl.ret_valid, fl.ret_told[0], fl.ret_told[1]);
         end
      end
   end
   task automatic push(string tag, sig_e s, int v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      if (v >= 0) sb.push_back(e);
   endtask
   task automatic expect_state(string tag, int p0, int p1, int cnt, int stall);
      push({tag, ".pr0"}, S_PR0, p0);
      push({tag, ".pr1"}, S_PR1, p1);
      push({tag, ".count"}, S_CNT, cnt);
      push({tag, ".stall"}, S_STALL, stall);
   endtask
   task automatic compare_out();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = (e.sig == S_PR0) ? 32'(fl.pr_freelist[0]) :
               (e.sig == S_PR1) ? 32'(fl.pr_freelist[1]) :
               (e.sig == S_CNT) ? 32'(fl.free_count) : 32'(fl.dis_stall);
         compared++;
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask
   task automatic drive(logic [1:0] dis, logic [1:0] rv, FREE_TAG t0, FREE_TAG t1, logic rb);
      fl.dis_req = dis;
      fl.ret_valid = rv;
      fl.ret_told[0] = t0;
      fl.ret_told[1] = t1;
      fl.rollback = rb;
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic observe(logic [1:0] dis);
      drive(dis, 2'b00, '0, '0, 1'b0);
      #1;
      compare_out();
   endtask
   task automatic do_reset();
      drive(2'b00, 2'b00, '0, '0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask
   initial begin
      drive(2'b00, 2'b00, '0, '0, 1'b0);
      tick();
      do_reset();
      expect_state("reset", 33, 34, 31, 0);
      observe(2'b11);
      tick();
      expect_state("pack2", 35, 36, 29, 0);
      observe(2'b11);
      expect_state("way1_only", -1, 35, 29, 0);
      observe(2'b10);
      tick();
      expect_state("after_way1", 36, -1, 28, 0);
      observe(2'b00);
      do_reset();
      drive(2'b11, 2'b11, 6'd5, 6'd7, 1'b0);
      tick();
      expect_state("alloc_and_retire", 35, -1, 31, 0);
      observe(2'b00);
      drive(2'b11, 2'b00, '0, '0, 1'b0);
      repeat (14) tick();
      expect_state("wrap_pair", 63, 5, 3, 0);
      observe(2'b11);
      tick();
      expect_state("wrap_next", 7, -1, 1, 1);
      observe(2'b01);
      do_reset();
      drive(2'b11, 2'b00, '0, '0, 1'b0);
      repeat (15) tick();
      expect_state("exhaust", 63, -1, 1, 1);
      observe(2'b01);
      drive(2'b11, 2'b00, '0, '0, 1'b0);
      tick();
      expect_state("reject_pair", 63, -1, 1, 1);
      observe(2'b01);
      tick();
      expect_state("empty", -1, -1, 0, 1);
      observe(2'b01);
      drive(2'b01, 2'b01, 6'd40, '0, 1'b0);
      tick();
      expect_state("free_next_cycle", 40, -1, 1, 1);
      observe(2'b01);
      do_reset();
      drive(2'b11, 2'b00, '0, '0, 1'b0);
      tick();
      tick();
      expect_state("pre_rollback", 37, 38, 27, 0);
      observe(2'b11);
      drive(2'b11, 2'b00, '0, '0, 1'b1);
      tick();
      expect_state("rollback", 33, 34, 31, 0);
      observe(2'b11);
      do_reset();
      drive(2'b01, 2'b00, '0, '0, 1'b0);
      tick();
      drive(2'b11, 2'b01, 6'd9, '0, 1'b1);
      tick();
      expect_state("rollback_retire", 34, 35, 31, 0);
      observe(2'b11);
      drive(2'b11, 2'b00, '0, '0, 1'b0);
      repeat (15) tick();
      expect_state("rollback_tail", 9, -1, 1, 1);
      observe(2'b01);
      drive(2'b11, 2'b11, 6'd3, 6'd4, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_state("mid_reset", 33, 34, 31, 0);
      observe(2'b11);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL provide the following ports, with clock and reset first:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- dis_req  in  [N_WAY]x1  per-way dispatch requests for a new physical tag.
- ret_valid  in  [N_WAY]x1  per-way retire valid.
- ret_told  in  [N_WAY]x[CDB_BITS]  old physical tag freed by each retiring instruction.
- rollback  in  1  full-pipeline squash; restore the architectural free list.
- pr_freelist  out  [N_WAY]x[CDB_BITS]  tag offered to each dispatch way.
- free_count  out  7  number of free tags currently held.
- dis_stall  out  1  high when free_count < N_WAY.
REQ-002 SHALL take the following parameters and constants from the shared package:
- N_WAY, default 2, dispatch/retire width.
- N_PHYS_REG, default 64, physical tags 0..63.
- CDB_BITS, default 6, tag width.
- FL_DEPTH, default 64, circular buffer entries.

Function
REQ-003 SHALL hold free tags in a FL_DEPTH-entry circular buffer with three 6-bit pointers: head (speculative allocate), tail (free/insert) and arch_head (retired allocate). All pointers wrap modulo 64.
REQ-004 SHALL keep tag 0 reserved: it is never allocated and never present in the buffer.
REQ-005 SHALL drive pr_freelist[k] combinationally as buf[head + number of dis_req set in ways 0..k-1]. Allocation is packed, so requesting ways receive consecutive entries in way order.
REQ-006 SHALL grant a dispatch only when popcount(dis_req) <= free_count.
- On grant: head advances by popcount(dis_req) at the clock edge.
- Otherwise: the request is ignored for the whole cycle, and head and free_count are unchanged.
REQ-007 SHALL drive dis_stall combinationally from the free_count register only, never from dis_req.
REQ-008 SHALL enqueue each ret_told[k] with ret_valid[k]=1 at buf[tail + number of ret_valid set in ways 0..k-1]. Tail advances by popcount(ret_valid).
REQ-009 SHALL advance arch_head by popcount(ret_valid) every cycle, because every retired instruction consumed exactly one tag at dispatch.
REQ-010 SHALL make tags freed in cycle t allocatable no earlier than cycle t+1. A same-cycle retire does not relax the REQ-006 grant test.
REQ-011 SHALL update free_count(t+1) = free_count - granted allocations + retired frees when alloc and retire occur in the same cycle.
REQ-012 SHALL, on rollback=1:
- set head to the arch_head value after this cycle's retirement;
- set free_count to (new tail - new arch_head) mod 64;
- ignore dis_req that cycle;
- still process retirement that cycle.
REQ-013 SHALL never produce free_count > 63. Retire with free_count = 63, or ret_told = 0, is illegal stimulus and is flagged by a bench assertion.

Reset
REQ-014 SHALL, on the reset cycle:
- load buf[i] = 33+i for i = 0..30;
- load all other entries with 0;
- set head = 0, arch_head = 0, tail = 31, free_count = 31.
This matches architectural registers 0..31 mapping to tags 1..32 at reset.
REQ-015 SHALL, after reset, output pr_freelist[k] = 33+k and dis_stall = 0.
REQ-016 SHALL give reset priority over rollback, dis_req and ret_valid. Reset asserted mid-operation discards all in-flight state.

Structure
REQ-017 SHALL define N_WAY, N_PHYS_REG, CDB_BITS, FL_DEPTH and a FREE_TAG typedef (CDB_BITS-bit) in the shared package.
REQ-018 SHALL use one sub-module, fl_prefix_count, instantiated once for dispatch and once for retire. It computes per-way exclusive prefix popcounts and the total popcount of an N_WAY-bit vector.

Verification
REQ-019 Reset: after reset -> pr_freelist = {33, 34}, free_count = 31, dis_stall = 0.
REQ-020 Packed allocation:
- dis_req = {1,1} for one cycle -> next cycle pr_freelist = {35, 36}, free_count = 29.
- Then dis_req = {0,1} -> way1 receives 35, and next head offers 36.
REQ-021 Simultaneous events: dis_req = {1,1} and retire {5, 7} in the same cycle -> free_count stays 31. Tags 5 and 7 are offered only after tags 35..63 have been consumed, following pointer wrap.
REQ-022 Exhaustion:
- 15 cycles of dis_req = {1,1} -> free_count = 1, dis_stall = 1.
- Then dis_req = {1,1} -> rejected, with free_count = 1 and head unchanged.
- Then dis_req = {1,0} -> way0 receives tag 63, and free_count becomes 0.
REQ-023 Rollback: allocate 4 tags with no retirement, then assert rollback -> next cycle pr_freelist = {33, 34}, free_count = 31.
REQ-024 Rollback with retire: rollback asserted in the same cycle as retiring 1 instruction (told = 9) -> head = arch_head = 1 and free_count = 31, with tag 9 at the tail.
